// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_rx_if.sv
// Bus-side outputs of the UART receiver, bundled for the bridge.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  frame_err;
  logic                  rx_busy;

  modport master (output data_out, output data_valid, output frame_err, output rx_busy);
  modport slave  (input  data_out, input  data_valid, input  frame_err, input  rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Line conditioning for uart_rx: 2-FF synchronizer, a registered copy of the
// synchronized line, and (with UART_RX_MAJORITY_EN defined) a 3-deep history
// feeding a 2-of-3 voter for the sample points.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic rx_line,    // synchronized line, used for edge/level detection
  output logic rx_sample   // value used at bit sample points
);

  logic sync1_reg;
  logic sync2_reg;
  logic line_reg;

  // Two-stage synchronizer plus one output register; everything resets to idle level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_reg <= UART_IDLE_LVL;
      sync2_reg <= UART_IDLE_LVL;
      line_reg  <= UART_IDLE_LVL;
    end else begin
      sync1_reg <= rx;
      sync2_reg <= sync1_reg;
      line_reg  <= sync2_reg;
    end
  end

  assign rx_line = line_reg;

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist_reg;

  // History of the synchronized line; the voter spans three consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_reg <= {3{UART_IDLE_LVL}};
    end else begin
      hist_reg <= {hist_reg[1:0], sync2_reg};
    end
  end

  // A single-cycle glitch can corrupt at most one of the three votes.
  assign rx_sample = (hist_reg[0] & hist_reg[1]) |
                     (hist_reg[0] & hist_reg[2]) |
                     (hist_reg[1] & hist_reg[2]);
`else
  assign rx_sample = line_reg;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1-style framing, LSB first). Recovers DATA_WIDTH-bit words
// from the serial line and presents them as one-cycle pulses on the bus
// interface. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int DATA_WIDTH       = 8
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  logic rx_line;
  logic rx_sample;

  rx_state_t             state_reg;
  logic [CNT_W-1:0]      clk_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  data_valid_reg;
  logic                  frame_err_reg;
  logic                  rx_busy_reg;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .rx_line   (rx_line),
    .rx_sample (rx_sample)
  );

  // Receiver FSM: counters, shift register and registered outputs in one place.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= RX_IDLE;
      clk_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      rx_busy_reg    <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          if (rx_line == UART_START_LVL) begin
            state_reg   <= RX_START;
            clk_cnt_reg <= '0;
            rx_busy_reg <= 1'b1;
          end
        end
        RX_START: begin
          if (clk_cnt_reg == HALF_LAST) begin
            if (rx_sample == UART_START_LVL) begin
              state_reg   <= RX_DATA;
              clk_cnt_reg <= '0;
              bit_cnt_reg <= '0;
            end else begin
              // Line went back high before mid-start: treat as noise.
              state_reg   <= RX_IDLE;
              rx_busy_reg <= 1'b0;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt_reg == FULL_LAST) begin
            shift_reg   <= {rx_sample, shift_reg[DATA_WIDTH-1:1]};
            clk_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
              state_reg <= RX_STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt_reg == FULL_LAST) begin
            clk_cnt_reg <= '0;
            if (rx_sample == UART_IDLE_LVL) begin
              // Back to idle at mid-stop so a back-to-back start edge is caught.
              data_out_reg   <= shift_reg;
              data_valid_reg <= 1'b1;
              state_reg      <= RX_IDLE;
              rx_busy_reg    <= 1'b0;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= RX_BREAK;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        RX_BREAK: begin
          // A held-low line must not decode as a stream of zero words.
          if (rx_line == UART_IDLE_LVL) begin
            state_reg   <= RX_IDLE;
            rx_busy_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= RX_IDLE;
          rx_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.frame_err  = frame_err_reg;
  assign bus.rx_busy    = rx_busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A line-level model predicts every output
// from mid-bit samples of the driven rx waveform; directed frames with
// hand-computed results pin the model. Honours UART_RX_MAJORITY_EN.
module tb_uart_rx;
  localparam int C = 16;
  localparam int D = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rx   = 1'b1;

  uart_rx_if #(.DATA_WIDTH(D)) bus ();

  uart_rx #(.CLOCKS_PER_PULSE(C), .DATA_WIDTH(D)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- line-level model ----------------
  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_BREAK = 2;

  bit             rx_hist [0:8191];
  int             reset_edge = -1;
  int             mode = M_IDLE;
  int             t_m  = 0;
  logic [D-1:0]   m_data  = '0;
  logic           m_valid = 1'b0;
  logic           m_ferr  = 1'b0;
  logic           m_busy  = 1'b0;

  // Line level as seen at a given edge; reset forces the receiver's view high.
  function automatic bit rxv(int i);
    if (i < 0 || i <= reset_edge) return 1'b1;
    return rx_hist[i];
  endfunction

  function automatic bit smp(int i);
`ifdef UART_RX_MAJORITY_EN
    bit a, b, c;
    a = rxv(i); b = rxv(i - 1); c = rxv(i - 2);
    return (a & b) | (a & c) | (b & c);
`else
    return rxv(i);
`endif
  endfunction

  always @(posedge clk) begin
    logic [D-1:0] w;
    cyc++;
    rx_hist[cyc] = rx;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (!rstn) begin
      mode = M_IDLE; m_data = '0; m_busy = 1'b0; reset_edge = cyc;
    end else if (mode == M_IDLE) begin
      if (rxv(cyc - 3) == 1'b0) begin
        mode = M_FRAME; t_m = cyc - 3; m_busy = 1'b1;
      end
    end else if (mode == M_FRAME) begin
      if (cyc == t_m + 3 + C/2) begin
        if (smp(t_m + C/2)) begin mode = M_IDLE; m_busy = 1'b0; end
      end else if (cyc == t_m + 3 + C/2 + (D + 1) * C) begin
        if (smp(t_m + C/2 + (D + 1) * C)) begin
          for (int k = 0; k < D; k++) w[k] = smp(t_m + C/2 + (k + 1) * C);
          m_data = w; m_valid = 1'b1; mode = M_IDLE; m_busy = 1'b0;
        end else begin
          m_ferr = 1'b1; mode = M_BREAK;
        end
      end
    end else begin
      if (rxv(cyc - 3) == 1'b1) begin mode = M_IDLE; m_busy = 1'b0; end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    check("data_out",   32'(bus.data_out),   32'(m_data));
    check("data_valid", 32'(bus.data_valid), 32'(m_valid));
    check("frame_err",  32'(bus.frame_err),  32'(m_ferr));
    check("rx_busy",    32'(bus.rx_busy),    32'(m_busy));
  end

  // Capture delivered words and pulse edges for the literal checks.
  logic [D-1:0] got_q [$];
  int           edge_q[$];
  int           n_valid = 0;
  int           n_ferr  = 0;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      got_q.push_back(bus.data_out);
      edge_q.push_back(cyc);
      n_valid++;
    end
    if (bus.frame_err === 1'b1) n_ferr++;
  end

  // ---------------- stimulus ----------------
  task automatic hold(logic lvl, int n);
    rx = lvl;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(logic [7:0] b, logic stop_lvl, bit glitch);
    hold(1'b0, C);
    for (int k = 0; k < D; k++) begin
      if (glitch) begin
        hold(b[k], C/2);
        hold(~b[k], 1);
        hold(b[k], C/2 - 1);
      end else begin
        hold(b[k], C);
      end
    end
    hold(stop_lvl, C);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t_edge;
    int v0, f0;
    logic [7:0] exp_b2b [2];
    logic [7:0] glitch_exp;
    exp_b2b[0] = 8'hA5;
    exp_b2b[1] = 8'h3C;
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h0F;
`else
    glitch_exp = 8'hF0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out",   32'(bus.data_out),   32'h0);
    check("rst_data_valid", 32'(bus.data_valid), 32'h0);
    check("rst_frame_err",  32'(bus.frame_err),  32'h0);
    check("rst_rx_busy",    32'(bus.rx_busy),    32'h0);
    rstn = 1'b1;
    hold(1'b1, 20);

    // Back-to-back frames; latency measured on the first.
    t_edge = cyc + 1;
    send(8'hA5, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    hold(1'b1, 2 * C);
    check("b2b_count", 32'(got_q.size()), 32'd2);
    for (int i = 0; i < 2; i++)
      check("b2b_word", (got_q.size() > i) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_b2b[i]));
    check("latency", (edge_q.size() > 0) ? 32'(edge_q[0] - t_edge) : 32'hDEAD, 32'd155);
    check("b2b_ferr", 32'(n_ferr), 32'd0);

    // Short low pulse on an idle line.
    v0 = n_valid; f0 = n_ferr;
    hold(1'b0, C/4);
    hold(1'b1, C);
    check("glitch_busy", 32'(bus.rx_busy), 32'h0);
    hold(1'b1, C);
    check("glitch_valid", 32'(n_valid), 32'(v0));
    check("glitch_ferr",  32'(n_ferr),  32'(f0));

    // Stop bit low, line held low for 40 bit periods.
    send(8'h55, 1'b0, 1'b0);
    hold(1'b0, 40 * C);
    check("break_busy",  32'(bus.rx_busy), 32'h1);
    check("break_ferr",  32'(n_ferr),      32'(f0 + 1));
    check("break_valid", 32'(n_valid),     32'(v0));
    check("break_data",  32'(bus.data_out), 32'h3C);
    hold(1'b1, 8);
    check("break_exit", 32'(bus.rx_busy), 32'h0);

    // Reset pulse during data bit 3 of a frame.
    hold(1'b1, C);
    hold(1'b0, C);
    hold(1'b0, 3 * C);
    hold(1'b1, C/2);
    rstn = 1'b0;
    hold(1'b1, 1);
    rstn = 1'b1;
    check("mid_rst_data", 32'(bus.data_out),   32'h0);
    check("mid_rst_busy", 32'(bus.rx_busy),    32'h0);
    check("mid_rst_vld",  32'(bus.data_valid), 32'h0);
    hold(1'b1, C);
    send(8'h81, 1'b1, 1'b0);
    hold(1'b1, 2 * C);
    check("after_rst_data", 32'(bus.data_out), 32'h81);

    // Glitch at every data-bit sample point.
    send(8'h0F, 1'b1, 1'b1);
    hold(1'b1, 2 * C);
    check("glitch_frame", 32'(bus.data_out), 32'(glitch_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
